button_event: RTL



---
 rtl/button_event_pkg.sv | 25 ++
 rtl/button_event_ms_timer.sv | 45 ++++
 rtl/button_event.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/button_event_pkg.sv
// Shared types and elaboration-time helpers for the button_event classifier.
package button_event_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_LONG_HELD,
    ST_WAIT_SECOND,
    ST_SECOND_PRESSED
  } btn_state_t;

  function automatic int cyc_per_ms(input int freq);
    return freq / 1000;
  endfunction

  // Wide enough to hold the largest millisecond threshold without wrapping.
  function automatic int ms_cnt_width(input int long_ms, input int dbl_ms, input int repeat_ms);
    int m;
    m = long_ms;
    if (dbl_ms > m) m = dbl_ms;
    if (repeat_ms > m) m = repeat_ms;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_event_ms_timer.sv
// Millisecond timebase: a clock prescaler feeding a saturating ms counter,
// both restarted by a synchronous clear.
module ms_timer #(
  parameter int CYC_PER_MS = 50000,
  parameter int CNT_W      = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  output logic [CNT_W-1:0] ms_cnt
);

  localparam int PW = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(CYC_PER_MS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ms_tick;

  assign ms_tick = (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = ms_tick ? '0 : presc_q + PW'(1);
    cnt_d   = cnt_q;
    if (ms_tick && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
    if (clear) begin
      presc_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ms_cnt = cnt_q;

endmodule

// File: rtl/button_event.sv
// Classifies debounced presses into short/long/double (and optional repeat)
// one-cycle pulses. Define BUTTON_EVENT_REPEAT_EN to enable auto-repeat in LONG_HELD.
module button_event
  import button_event_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int LONG_MS   = 1000,
  parameter int DBL_MS    = 300,
  parameter int REPEAT_MS = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic repeat_press,
  output logic busy
);

  localparam int CYC_PER_MS = cyc_per_ms(CLK_FREQ);
  localparam int CNT_W      = ms_cnt_width(LONG_MS, DBL_MS, REPEAT_MS);
  localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'(LONG_MS);
  localparam logic [CNT_W-1:0] DBL_CNT  = CNT_W'(DBL_MS);

  btn_state_t       state_q, state_d;
  logic             lvl_q;
  logic             rise, fall;
  logic [CNT_W-1:0] ms_cnt;
  logic             timer_clear;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             double_q, double_d;
  logic             busy_q;

  assign rise = level & ~lvl_q;
  assign fall = ~level & lvl_q;

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_CNT = CNT_W'(REPEAT_MS);
  logic repeat_q, repeat_d;
  logic rep_restart;
`endif

  // Edges are tested before expiries so a coincident edge always wins.
  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
    repeat_d    = 1'b0;
    rep_restart = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_PRESSED;
      end
      ST_PRESSED: begin
        if (fall) begin
          state_d = ST_WAIT_SECOND;
        end else if (ms_cnt == LONG_CNT) begin
          long_d  = 1'b1;
          state_d = ST_LONG_HELD;
        end
      end
      ST_LONG_HELD: begin
        if (fall) begin
          state_d = ST_IDLE;
        end
`ifdef BUTTON_EVENT_REPEAT_EN
        else if (ms_cnt == REP_CNT) begin
          repeat_d    = 1'b1;
          rep_restart = 1'b1;
        end
`endif
      end
      ST_WAIT_SECOND: begin
        if (rise) begin
          state_d = ST_SECOND_PRESSED;
        end else if (ms_cnt == DBL_CNT) begin
          short_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_SECOND_PRESSED: begin
        if (fall) begin
          double_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (ms_cnt == LONG_CNT) begin
          long_d  = 1'b1;
          state_d = ST_LONG_HELD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef BUTTON_EVENT_REPEAT_EN
  assign timer_clear = (state_d != state_q) | rep_restart;
`else
  assign timer_clear = (state_d != state_q);
`endif

  ms_timer #(
    .CYC_PER_MS(CYC_PER_MS),
    .CNT_W     (CNT_W)
  ) u_ms_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .ms_cnt(ms_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      lvl_q    <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lvl_q    <= level;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      busy_q   <= (state_d != ST_IDLE);
    end
  end

`ifdef BUTTON_EVENT_REPEAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) repeat_q <= 1'b0;
    else       repeat_q <= repeat_d;
  end
  assign repeat_press = repeat_q;
`else
  assign repeat_press = 1'b0;
`endif

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_press = double_q;
  assign busy         = busy_q;

endmodule
